// File: rtl/oclib_ram_fifo.sv
// Valid/ready FIFO on a simple dual-port RAM. A small prefetch buffer absorbs the
// RAM read latency, so the head word falls through and one push plus one pop can happen every cycle.

module oclib_ram1r1w #(
    parameter int    Width   = 32,
    parameter int    Depth   = 32,
    parameter int    Latency = 1,
    parameter string Macro   = "auto"
) (
    input  logic                     clock,
    input  logic                     write,
    input  logic [$clog2(Depth)-1:0] write_address,
    input  logic [Width-1:0]         write_data,
    input  logic                     read,
    input  logic [$clog2(Depth)-1:0] read_address,
    output logic [Width-1:0]         read_data
);
    logic [Width-1:0] raw_data;

    // NOTE: the storage array has no reset; a location is never read before it has been written.
    if (Macro == "flops") begin : g_flops
        (* ram_style = "registers" *) logic [Width-1:0] mem [Depth];
        always_ff @(posedge clock) begin
            if (write) mem[write_address] <= write_data;
        end
        assign raw_data = mem[read_address];
    end else begin : g_ram
        (* ram_style = "block" *) logic [Width-1:0] mem [Depth];
        always_ff @(posedge clock) begin
            if (write) mem[write_address] <= write_data;
        end
        assign raw_data = mem[read_address];
    end

    if (Latency == 0) begin : g_comb
        assign read_data = raw_data;
    end else begin : g_pipe
        logic [Width-1:0] pipe [Latency];
        always_ff @(posedge clock) begin
            if (read) pipe[0] <= raw_data;
            for (int i = 1; i < Latency; i++) pipe[i] <= pipe[i-1];
        end
        assign read_data = pipe[Latency-1];
    end
endmodule

module oclib_ram_fifo #(
    parameter int    Width      = 32,
    parameter int    Depth      = 32,
    parameter int    Latency    = 1,
    parameter string Macro      = "auto",
    parameter int    AlmostFull = Depth - 2
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [Width-1:0]                   inData,
    input  logic                               inValid,
    output logic                               inReady,
    output logic [Width-1:0]                   outData,
    output logic                               outValid,
    input  logic                               outReady,
    output logic [$clog2(Depth+Latency+2)-1:0] count,
    output logic                               almostFull
);
    localparam int AW       = $clog2(Depth);
    localparam int CW       = $clog2(Depth + Latency + 2);
    localparam int BufDepth = Latency + 1;
    localparam int BW       = $clog2(BufDepth + 1);
    localparam int BI       = (BufDepth > 1) ? $clog2(BufDepth) : 1;

    localparam logic [AW:0]   FullLevel = (AW+1)'(Depth);
    localparam logic [AW:0]   AfLevel   = (AW+1)'(AlmostFull);
    localparam logic [BI-1:0] BufLast   = BI'(BufDepth - 1);
    localparam logic [BW-1:0] BufFull   = BW'(BufDepth);
    localparam logic [CW-1:0] BufSlots  = CW'(BufDepth);
    localparam logic [CW-1:0] MaxCount  = CW'(Depth + Latency + 1);

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      ram_count, ram_count_next, readable;
    logic             push, pop, push_d, read_issue, returning;
    logic [CW-1:0]    inflight_cnt, pending;
    logic [BW-1:0]    buf_occ;
    logic [BI-1:0]    buf_wr, buf_rd;
    logic [Width-1:0] buffer [BufDepth];
    logic [Width-1:0] read_data;

    assign push     = inValid & inReady;
    assign outValid = (buf_occ != '0);
    assign pop      = outValid & outReady;

    // A word written on the previous edge is not yet safe to read from the RAM.
    assign readable       = ram_count - (AW+1)'(push_d);
    assign pending        = CW'(buf_occ) + inflight_cnt - CW'(pop);
    assign read_issue     = (readable != '0) && (pending < BufSlots);
    assign ram_count_next = ram_count + (AW+1)'(push) - (AW+1)'(read_issue);

    assign outData    = buffer[buf_rd];
    assign count      = CW'(ram_count) + inflight_cnt + CW'(buf_occ);
    assign almostFull = (ram_count >= AfLevel);

    oclib_ram1r1w #(
        .Width   (Width),
        .Depth   (Depth),
        .Latency (Latency),
        .Macro   (Macro)
    ) u_ram (
        .clock         (clock),
        .write         (push),
        .write_address (wr_ptr),
        .write_data    (inData),
        .read          (read_issue),
        .read_address  (rd_ptr),
        .read_data     (read_data)
    );

    // Zero-latency RAM data is captured into the buffer on the very edge the read issues.
    if (Latency == 0) begin : g_no_flight
        assign returning    = read_issue;
        assign inflight_cnt = '0;
    end else begin : g_flight
        logic [Latency-1:0] inflight;
        always_ff @(posedge clock) begin
            if (reset) inflight <= '0;
            else       inflight <= (inflight << 1) | Latency'(read_issue);
        end
        assign returning    = inflight[Latency-1];
        assign inflight_cnt = CW'($countones(inflight));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            push_d    <= 1'b0;
            buf_occ   <= '0;
            buf_wr    <= '0;
            buf_rd    <= '0;
            inReady   <= 1'b0;
        end else begin
            if (push)       wr_ptr <= wr_ptr + 1'b1;
            if (read_issue) rd_ptr <= rd_ptr + 1'b1;
            if (returning)  buf_wr <= (buf_wr == BufLast) ? '0 : buf_wr + 1'b1;
            if (pop)        buf_rd <= (buf_rd == BufLast) ? '0 : buf_rd + 1'b1;
            ram_count <= ram_count_next;
            push_d    <= push;
            buf_occ   <= buf_occ + BW'(returning) - BW'(pop);
            inReady   <= (ram_count_next < FullLevel);
        end
    end

    always_ff @(posedge clock) begin
        if (returning) buffer[buf_wr] <= read_data;
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (!reset) begin
            assert (!(returning && !pop && buf_occ == BufFull))
                else $error("oclib_ram_fifo: prefetch buffer overflow");
            assert (count <= MaxCount)
                else $error("oclib_ram_fifo: count out of range");
        end
    end
`endif
endmodule
